// File: rtl/buffer_arbiter.sv
// Two-requester write arbiter in front of a small buffer: round-robin on contention,
// tracks buffer occupancy locally so pushes never overflow and pulls never underflow.
module buffer_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  input  logic              pull_req,
  output logic              buf_push,
  output logic [DATA_W-1:0] buf_tail,
  output logic              buf_pull,
  output logic [2:0]        level,
  output logic              full,
  output logic              empty
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  typedef enum logic {LAST_A, LAST_B} last_t;

  last_t             last_gnt, last_gnt_nxt;
  logic [2:0]        occ, occ_nxt;
  logic [DATA_W-1:0] tail_nxt;
  logic              win_a, win_b, do_pull;

  // Simultaneous push and pull cancel; callers guarantee bounds via eligibility.
  function automatic logic [2:0] next_occ(input logic [2:0] cur, input logic push,
                                          input logic pull);
    logic [2:0] r;
    r = cur;
    if (push && !pull) r = cur + 3'd1;
    else if (pull && !push) r = cur - 3'd1;
    return r;
  endfunction

  always_comb begin
    win_a        = 1'b0;
    win_b        = 1'b0;
    last_gnt_nxt = last_gnt;
    tail_nxt     = buf_tail;
    if (occ < DEPTH_L) begin
      if (req_a && (!req_b || last_gnt == LAST_B)) begin
        win_a        = 1'b1;
        last_gnt_nxt = LAST_A;
        tail_nxt     = data_a;
      end else if (req_b) begin
        win_b        = 1'b1;
        last_gnt_nxt = LAST_B;
        tail_nxt     = data_b;
      end
    end
    do_pull = pull_req && (occ != 3'd0);
    occ_nxt = next_occ(occ, win_a | win_b, do_pull);
  end

  // Registered grant/buffer-control stage; buffer shares this reset so occ may be zeroed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      buf_push <= 1'b0;
      buf_pull <= 1'b0;
      buf_tail <= '0;
      occ      <= 3'd0;
      full     <= 1'b0;
      empty    <= 1'b1;
      last_gnt <= LAST_B;
    end else begin
      gnt_a    <= win_a;
      gnt_b    <= win_b;
      buf_push <= win_a | win_b;
      buf_pull <= do_pull;
      buf_tail <= tail_nxt;
      occ      <= occ_nxt;
      full     <= (occ_nxt == DEPTH_L);
      empty    <= (occ_nxt == 3'd0);
      last_gnt <= last_gnt_nxt;
    end
  end

  assign level = occ;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter: linear stimulus with hand-computed expectations.
module tb_buffer_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_a, req_b, pull_req;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, buf_push, buf_pull, full, empty;
  logic [7:0] buf_tail;
  logic [2:0] level;

  int vectors = 0;
  int miscompares = 0;

  buffer_arbiter #(.DATA_W(8), .DEPTH(7)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .pull_req(pull_req), .buf_push(buf_push), .buf_tail(buf_tail),
    .buf_pull(buf_pull), .level(level), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full snapshot of outputs; push/grant consistency is checked every time.
  task automatic expect_all(input string tag, input logic ga, input logic gb, input logic pl,
                            input logic [7:0] tl, input logic [2:0] lv);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(ga));
    chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(gb));
    chk({tag, ".buf_push"}, 32'(buf_push), 32'(ga | gb));
    chk({tag, ".buf_pull"}, 32'(buf_pull), 32'(pl));
    chk({tag, ".buf_tail"}, 32'(buf_tail), 32'(tl));
    chk({tag, ".level"}, 32'(level), 32'(lv));
    chk({tag, ".full"}, 32'(full), 32'(lv == 3'd7));
    chk({tag, ".empty"}, 32'(empty), 32'(lv == 3'd0));
  endtask

  initial begin
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; pull_req = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    tick();
    expect_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);

    // Fill from A alone: seven grants, then held off at full.
    reset = 1'b1;
    req_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      data_a = 8'(i);
      tick();
      expect_all($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, 8'(i), 3'(i));
    end
    data_a = 8'h08;
    tick();
    expect_all("fill_full", 1'b0, 1'b0, 1'b0, 8'h07, 3'd7);

    // Full with request and pull at the same edge: pull wins, push next edge.
    data_a = 8'h55;
    pull_req = 1'b1;
    tick();
    expect_all("full_pull", 1'b0, 1'b0, 1'b1, 8'h07, 3'd6);
    tick();
    expect_all("after_full", 1'b1, 1'b0, 1'b1, 8'h55, 3'd6);

    // Pulls at empty are held off.
    req_a = 1'b0; pull_req = 1'b0;
    reset = 1'b0;
    tick();
    expect_all("reset2", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    reset = 1'b1;
    pull_req = 1'b1;
    tick();
    expect_all("empty_pull1", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    tick();
    expect_all("empty_pull2", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);

    // Contention alternates starting with A after reset.
    pull_req = 1'b0;
    req_a = 1'b1; req_b = 1'b1; data_a = 8'hA0; data_b = 8'hB0;
    tick();
    expect_all("rr1", 1'b1, 1'b0, 1'b0, 8'hA0, 3'd1);
    tick();
    expect_all("rr2", 1'b0, 1'b1, 1'b0, 8'hB0, 3'd2);
    tick();
    expect_all("rr3", 1'b1, 1'b0, 1'b0, 8'hA0, 3'd3);
    tick();
    expect_all("rr4", 1'b0, 1'b1, 1'b0, 8'hB0, 3'd4);

    // Drop to level 3, then simultaneous push/pull holds the level.
    req_a = 1'b0; req_b = 1'b0; pull_req = 1'b1;
    tick();
    expect_all("pull_to3", 1'b0, 1'b0, 1'b1, 8'hB0, 3'd3);
    req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_b = 8'hC0 + 8'(i);
      tick();
      expect_all($sformatf("pushpull%0d", i), 1'b0, 1'b1, 1'b1, 8'hC0 + 8'(i), 3'd3);
    end

    // Reach level 5, then mid-operation reset discards the request.
    req_b = 1'b0; pull_req = 1'b0; req_a = 1'b1; data_a = 8'h11;
    tick();
    expect_all("to4", 1'b1, 1'b0, 1'b0, 8'h11, 3'd4);
    data_a = 8'h12;
    tick();
    expect_all("to5", 1'b1, 1'b0, 1'b0, 8'h12, 3'd5);
    data_a = 8'h13;
    reset = 1'b0;
    tick();
    expect_all("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    reset = 1'b1;
    tick();
    expect_all("post_reset", 1'b1, 1'b0, 1'b0, 8'h13, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of the requester data paths and of buf_tail.
REQ-002 Parameter DEPTH, default 7, maximum buffer occupancy (the 3-bit buffer counter saturates at 7).
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block.
REQ-005 req_a  input  1  requester A wants to write one word.
REQ-006 data_a  input  DATA_W  requester A write data.
REQ-007 gnt_a  output  1  registered one-cycle pulse; A's word was taken.
REQ-008 req_b  input  1  requester B wants to write one word.
REQ-009 data_b  input  DATA_W  requester B write data.
REQ-010 gnt_b  output  1  registered one-cycle pulse; B's word was taken.
REQ-011 pull_req  input  1  consumer wants one word from the buffer.
REQ-012 buf_push  output  1  registered; drives the buffer push input.
REQ-013 buf_tail  output  DATA_W  registered; drives the buffer tail input.
REQ-014 buf_pull  output  1  registered; drives the buffer pull input.
REQ-015 level  output  3  registered internal occupancy count.
REQ-016 full  output  1  registered; high when level==DEPTH.
REQ-017 empty  output  1  registered; high when level==0.

Function
REQ-018 Occupancy tracked internally (occ); the block shall not read the buffer counter.
REQ-019 Push eligible at an edge iff occ<DEPTH; pull eligible iff occ>0; both judged on occ before that edge's update.
REQ-020 At an edge with push eligible and exactly one of req_a/req_b high, that requester shall win.
REQ-021 At an edge with push eligible and both high, the winner shall be the requester not granted most recently (last_gnt register); after reset last_gnt=B, so A wins the first contention.
REQ-022 Winner X at edge N: gnt_X=1, buf_push=1, buf_tail=data_X (sampled at edge N), last_gnt=X, all visible from edge N; de-asserted at edge N+1 unless re-granted.
REQ-023 A requester holding req high shall receive at most one grant per cycle; back-to-back grants permitted.
REQ-024 At most one of gnt_a/gnt_b high in any cycle; buf_push == gnt_a|gnt_b.
REQ-025 pull_req high and pull eligible at edge N: buf_pull=1 for the cycle after edge N, else 0.
REQ-026 Push and pull issued at the same edge: occ unchanged; push only: occ+1; pull only: occ-1.
REQ-027 occ shall never exceed DEPTH nor go below 0; requests at full or pulls at empty are held off (no grant, no buf_pull) and do not change occ.
REQ-028 level=occ, full=(occ==DEPTH), empty=(occ==0), all updated at the same edge as occ.
REQ-029 When not granted, buf_tail shall hold its last value.
REQ-030 At full with pull_req and a request at the same edge: pull issued, push withheld; push eligible from the next edge.

Reset
REQ-031 reset=0 at an edge: gnt_a=0, gnt_b=0, buf_push=0, buf_pull=0, buf_tail=0, occ=level=0, empty=1, full=0, last_gnt=B.
REQ-032 While reset=0, all requests and pull_req are ignored.
REQ-033 Reset asserted mid-operation discards any in-flight grant and zeroes occ the same edge; the downstream buffer shares this reset.
REQ-034 The first edge with reset=1 evaluates requests normally against occ=0.

Verification
REQ-035 Reset, req_a=1, data_a=1..7 on consecutive cycles, req_b=0 -> seven gnt_a pulses, buf_tail 1..7, level 7, full=1; eighth request: no grant.
REQ-036 From empty, req_a=req_b=1 held 4 cycles, data_a=8'hA0, data_b=8'hB0 -> grants A,B,A,B; buf_tail A0,B0,A0,B0; level 4.
REQ-037 level=7, req_a=1 and pull_req=1 at one edge -> buf_pull=1, no gnt_a, level 6; next edge gnt_a=1, buf_pull=1, level 6.
REQ-038 level=3, req_b=1 and pull_req=1 for 3 cycles -> 3 gnt_b and 3 buf_pull pulses, level stays 3.
REQ-039 Empty, pull_req=1 for 2 cycles -> buf_pull stays 0, empty stays 1, level 0.
REQ-040 level=5, reset=0 for one edge while req_a=1 -> all outputs at reset values; next edge with reset=1 gnt_a=1, level 1.
